// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC streaming path.
package adc_pkg;

  localparam int unsigned ADC_DATA_WIDTH = 32;
  localparam int unsigned DECIM_MAX_LOG2 = 8;

  typedef logic signed [ADC_DATA_WIDTH-1:0] adc_sample_t;

  // Limit a requested decimation exponent to the supported maximum.
  function automatic logic [3:0] clamp_log2(input logic [3:0] k, input logic [3:0] k_max);
    return (k > k_max) ? k_max : k;
  endfunction

endpackage

// File: rtl/adc_stream_decimator.sv
// Boxcar-mean decimator: averages every 2^k accepted samples into one output.
// k = 0 degenerates to a registered pass-through. Upstream is stalled only when
// a completed block could not be stored because the output is still pending.
module adc_stream_decimator
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int unsigned MAX_LOG2   = DECIM_MAX_LOG2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [3:0]            decim_log2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           out_count
);

  localparam int unsigned ACC_W = DATA_WIDTH + MAX_LOG2;
  localparam logic [3:0]  K_MAX = 4'(MAX_LOG2);

  logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [MAX_LOG2-1:0]      cnt_q, cnt_d;
  logic [3:0]               k_act_q, k_act_d, k_clamp, k_cur;
  logic [MAX_LOG2:0]        last_idx;
  logic                     last, s_ready, s_fire, load;
  logic [DATA_WIDTH-1:0]    mean;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_fire;
  logic [31:0]              out_count_q, out_count_d;

  // Block position, handshakes and next state for both register groups.
  // At a block boundary the freshly clamped k is used directly, so the first
  // sample of a block already sees the new exponent (needed for k = 0).
  always_comb begin
    k_clamp  = clamp_log2(decim_log2, K_MAX);
    k_cur    = (cnt_q == '0) ? k_clamp : k_act_q;
    last_idx = ((MAX_LOG2+1)'(1) << k_cur) - (MAX_LOG2+1)'(1);
    last     = ({1'b0, cnt_q} == last_idx);

    s_ready  = resetn && enable && !(last && m_valid_q && !m_axis_tready);
    s_fire   = s_axis_tvalid && s_ready;
    load     = s_fire && last;
    m_fire   = m_valid_q && m_axis_tready;

    sum      = acc_q + {{MAX_LOG2{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
    mean     = DATA_WIDTH'(sum >>> k_cur);

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    k_act_d  = (cnt_q == '0) ? k_clamp : k_act_q;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s_fire) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + MAX_LOG2'(1);
      end
    end

    m_data_d    = load ? mean : m_data_q;
    m_valid_d   = load ? 1'b1 : (m_fire ? 1'b0 : m_valid_q);
    out_count_d = m_fire ? out_count_q + 32'd1 : out_count_q;
  end

  // Block counter, accumulator and latched exponent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      k_act_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_act_q <= k_act_d;
    end
  end

  // Output register and downstream handshake counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      out_count_q <= out_count_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign out_count     = out_count_q;

endmodule

// File: tb/tb_adc_stream_decimator.sv
// Self-checking bench for adc_stream_decimator with a queue-based mean model.
module tb_adc_stream_decimator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [3:0]  decim_log2;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] out_count;

  logic        bp_mode = 1'b0;
  logic        bp_rand = 1'b1;
  logic        m_rdy_force = 1'b1;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  longint      blk_q[$];
  int          blk_k;
  int unsigned model_cnt = 0;
  longint      msum, mdiv, mq;

  adc_stream_decimator #(.DATA_WIDTH(32), .MAX_LOG2(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .decim_log2    (decim_log2),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .out_count     (out_count)
  );

  always #5 clk = ~clk;

  assign m_axis_tready = bp_mode ? bp_rand : m_rdy_force;

  always @(negedge clk) bp_rand = ($urandom_range(0, 3) != 0);

  // Reference model: collect accepted samples per block, emit floor(sum / 2^k).
  always @(posedge clk) begin
    if (!resetn) begin
      blk_q.delete();
      model_cnt = 0;
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(m_axis_tdata);
        model_cnt++;
      end
      if (!enable) begin
        blk_q.delete();
      end else if (s_axis_tvalid && s_axis_tready) begin
        if (blk_q.size() == 0) blk_k = (decim_log2 > 8) ? 8 : int'(decim_log2);
        blk_q.push_back(longint'($signed(s_axis_tdata)));
        if (blk_q.size() == (1 << blk_k)) begin
          msum = 0;
          foreach (blk_q[j]) msum += blk_q[j];
          mdiv = longint'(1) << blk_k;
          mq = msum / mdiv;
          if ((msum % mdiv) != 0 && msum < 0) mq = mq - 1;
          exp_q.push_back(mq[31:0]);
          blk_q.delete();
        end
      end
    end
  end

  // Present one sample until accepted; entered between a negedge and the next posedge.
  task automatic send(input logic [31:0] d);
    logic acc;
    int   n;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      #1 acc = s_axis_tready;
      @(negedge clk);
      n++;
    end while (!acc && n < 2000);
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %h not accepted, required acceptance within 2000 cycles", d);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((got_q.size() != exp_q.size() || m_axis_tvalid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_drain: got %0d outputs, required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic start_test();
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; decim_log2 = 4'd0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h required 00000000", m_axis_tdata); end
    checks++; if (out_count !== 32'h0) begin errors++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b required 0", s_axis_tready); end
    resetn = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready: got %b required 1", s_axis_tready); end
  endtask

  task automatic test_passthrough();
    start_test();
    decim_log2 = 4'd0;
    send(32'h8BADF00D);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h8BADF00D) begin errors++; $display("FAIL pass_first: got v=%b %h required v=1 8badf00d", m_axis_tvalid, m_axis_tdata); end
    send(32'h00000001);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00000001) begin errors++; $display("FAIL pass_second: got v=%b %h required v=1 00000001", m_axis_tvalid, m_axis_tdata); end
    wait_drain("pass");
    checks++; if (got_q.size() != 2 || got_q[0] !== 32'h8BADF00D || got_q[1] !== 32'h1) begin errors++; $display("FAIL pass_stream: got %0d outputs, required 8badf00d,00000001", got_q.size()); end
  endtask

  task automatic test_k2();
    start_test();
    decim_log2 = 4'd2;
    send(32'd4); send(32'd8); send(32'd12); send(32'd16);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd10) begin errors++; $display("FAIL k2_mean: got v=%b %h required v=1 0000000a", m_axis_tvalid, m_axis_tdata); end
    send(32'hFFFFFFFF); send(32'hFFFFFFFF); send(32'hFFFFFFFF); send(32'hFFFFFFFE);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL k2_floor: got v=%b %h required v=1 fffffffe", m_axis_tvalid, m_axis_tdata); end
    wait_drain("k2");
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL k2_count: got %0d required 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL k2_model[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_k8();
    start_test();
    decim_log2 = 4'd8;
    for (int i = 0; i < 256; i++) begin
      send(32'h7FFFFFFF);
      if (i == 254) begin
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL k8_early: got tvalid=%b required 0 before sample 256", m_axis_tvalid); end
      end
    end
    checks++; if (m_axis_tdata !== 32'h7FFFFFFF) begin errors++; $display("FAIL k8_max: got %h required 7fffffff", m_axis_tdata); end
    for (int i = 0; i < 256; i++) send(32'h80000000);
    checks++; if (m_axis_tdata !== 32'h80000000) begin errors++; $display("FAIL k8_min: got %h required 80000000", m_axis_tdata); end
    wait_drain("k8");
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL k8_count: got %0d required 2", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    start_test();
    decim_log2 = 4'd1;
    m_rdy_force = 1'b0;
    send(32'd100); send(32'd201);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd150) begin errors++; $display("FAIL bp_first: got v=%b %h required v=1 00000096", m_axis_tvalid, m_axis_tdata); end
    send(32'hFFFFFFFB);
    s_axis_tdata  = 32'hFFFFFFFA;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: got s_tready=%b required 0", i, s_axis_tready); end
      checks++; if (m_axis_tdata !== 32'd150 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h required v=1 00000096", i, m_axis_tvalid, m_axis_tdata); end
      @(negedge clk);
    end
    m_rdy_force = 1'b1;
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_release: got s_tready=%b required 1", s_axis_tready); end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFFFFFFFA) begin errors++; $display("FAIL bp_second: got v=%b %h required v=1 fffffffa", m_axis_tvalid, m_axis_tdata); end
    wait_drain("bp");
    checks++; if (got_q.size() != 2 || got_q[0] !== 32'd150 || got_q[1] !== 32'hFFFFFFFA) begin errors++; $display("FAIL bp_order: got %0d outputs, required 00000096,fffffffa", got_q.size()); end
    checks++; if (out_count !== model_cnt) begin errors++; $display("FAIL bp_out_count: got %0d required %0d", out_count, model_cnt); end
  endtask

  task automatic test_k_change();
    start_test();
    decim_log2 = 4'd2;
    send(32'd10); send(32'd20);
    decim_log2 = 4'd1;
    send(32'd30); send(32'd40);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd25) begin errors++; $display("FAIL kchg_old: got v=%b %h required v=1 00000019", m_axis_tvalid, m_axis_tdata); end
    send(32'd50); send(32'd60);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd55) begin errors++; $display("FAIL kchg_new: got v=%b %h required v=1 00000037", m_axis_tvalid, m_axis_tdata); end
    decim_log2 = 4'd12;
    for (int i = 0; i < 256; i++) begin
      send(32'(i));
      if (i == 254) begin
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL kclamp_early: got tvalid=%b required 0", m_axis_tvalid); end
      end
    end
    checks++; if (m_axis_tdata !== 32'd127) begin errors++; $display("FAIL kclamp_mean: got %h required 0000007f", m_axis_tdata); end
    wait_drain("kchg");
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL kchg_count: got %0d required 3", got_q.size()); end
  endtask

  task automatic test_enable_flush();
    start_test();
    decim_log2 = 4'd2;
    send(32'd999); send(32'd999); send(32'd999);
    enable = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL en_refuse: got s_tready=%b required 0", s_axis_tready); end
    repeat (2) @(negedge clk);
    enable = 1'b1;
    send(32'd100); send(32'd100); send(32'd100); send(32'd100);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd100) begin errors++; $display("FAIL en_fresh: got v=%b %h required v=1 00000064", m_axis_tvalid, m_axis_tdata); end
    wait_drain("en");
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL en_count: got %0d required 1", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    start_test();
    decim_log2 = 4'd2;
    m_rdy_force = 1'b0;
    send(32'd40); send(32'd40); send(32'd40); send(32'd40);
    send(32'd1000); send(32'd1000);
    resetn = 1'b0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
    checks++; if (out_count !== 32'd0) begin errors++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL rst_tdata: got %h required 00000000", m_axis_tdata); end
    @(negedge clk);
    resetn = 1'b1;
    m_rdy_force = 1'b1;
    send(32'd7); send(32'd8); send(32'd9); send(32'd10);
    wait_drain("rst");
    checks++; if (got_q.size() != 1 || got_q[0] !== 32'd8) begin errors++; $display("FAIL rst_post_mean: got %0d outputs first %h, required 1 output 00000008", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx); end
    checks++; if (out_count !== 32'd1) begin errors++; $display("FAIL rst_post_count: got %0d required 1", out_count); end
  endtask

  task automatic test_random();
    start_test();
    bp_mode = 1'b1;
    decim_log2 = 4'd1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) decim_log2 = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0) begin
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send($urandom);
    end
    wait_drain("rand");
    checks++; if (got_q.size() != exp_q.size() || got_q.size() < 50) begin errors++; $display("FAIL rand_count: got %0d outputs required %0d (at least 50)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_model[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (out_count !== model_cnt) begin errors++; $display("FAIL rand_out_count: got %0d required %0d", out_count, model_cnt); end
    bp_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_k2();
    test_k8();
    test_back_to_back();
    test_k_change();
    test_enable_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
